pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
// Central pipeline controller for the 5-stage core. Computes the per-stage
// ctrl_signal (Default/Stalled/Bubble) consumed by the PC, IF_ID, ID_EX,
// EX_MEM and MEM_WB registers from load-use hazards, EX-stage redirects and
// memory wait. Sequences multi-cycle memory stalls and post-redirect flushes,
// and keeps stall/flush performance counters.
// PARAMETERS
// FLUSH_CYCLES  1   extra cycles IF_ID is bubbled after a redirect (imem latency); 0 legal
// CNT_W         32  width of the performance counters
// PORTS
// clk             in   1      core clock
// rst             in   1      synchronous active-high reset
// id_rs1_addr_i   in   5      rs1 of instruction in ID
// id_rs2_addr_i   in   5      rs2 of instruction in ID
// id_rs1_used_i   in   1      ID instruction reads rs1
// id_rs2_used_i   in   1      ID instruction reads rs2
// ex_rd_addr_i    in   5      rd of instruction in EX
// ex_wreg_i       in   1      EX instruction writes rd
// ex_is_load_i    in   1      EX instruction is a load
// ex_redirect_i   in   1      EX resolved taken branch/jump/trap (1-cycle pulse)
// mem_busy_i      in   1      dmem access in MEM not yet complete
// if_busy_i       in   1      imem fetch not yet returned
// ctrl_pc_o       out  2      PC register control
// ctrl_if_id_o    out  2      IF_ID control
// ctrl_id_ex_o    out  2      ID_EX control
// ctrl_ex_mem_o   out  2      EX_MEM control
// ctrl_mem_wb_o   out  2      MEM_WB control
// redirect_fire_o out  1      PC takes redirect target this cycle
// stall_cnt_o     out  CNT_W  cycles with ctrl_pc_o==Stalled
// flush_cnt_o     out  CNT_W  redirects applied
// BEHAVIOUR
// - Encodings (CTRL_Wire_Bus, 2b): Default=2'b00, Stalled=2'b01, Bubble=2'b10.
// - ctrl_*_o, redirect_fire_o combinational from state+inputs (zero latency);
//   state, counters, pending_redirect, flush_left registered.
// - rst high: state=RUN, counters=0, pending_redirect=0, flush_left=0; all
//   ctrl_*_o=Bubble except ctrl_pc_o=Stalled; redirect_fire_o=0.
// - FSM: RUN, MEM_WAIT, FLUSH. Priority in any state: mem_busy > redirect >
//   load-use > flush > if_busy.
// - mem_busy_i=1: pc/IF_ID/ID_EX/EX_MEM Stalled, MEM_WB Bubble; go MEM_WAIT.
//   ex_redirect_i seen here sets pending_redirect (not lost, not fired).
// - MEM_WAIT & mem_busy_i=0: if pending_redirect -> apply redirect this cycle,
//   clear it; else RUN outputs. Leave to FLUSH/RUN accordingly.
// - Redirect (ex_redirect_i or pending): redirect_fire_o=1, pc Default,
//   IF_ID and ID_EX Bubble, EX_MEM/MEM_WB Default; flush_cnt++;
//   flush_left=FLUSH_CYCLES; next FLUSH (RUN if FLUSH_CYCLES==0).
// - FLUSH: IF_ID Bubble, pc Default, others Default; flush_left--; RUN at 0.
//   New redirect in FLUSH reloads flush_left (re-arms, counted).
// - Load-use: ex_is_load_i & ex_wreg_i & ex_rd_addr_i!=0 & ((rs1_used &
//   rs1==rd)|(rs2_used & rs2==rd)): pc/IF_ID Stalled, ID_EX Bubble, rest
//   Default. Single cycle; no state change. Suppressed by redirect (ID is squashed).
// - if_busy_i only: pc Stalled, IF_ID Bubble, rest Default.
// - No condition: all Default.
// - Counters wrap modulo 2^CNT_W; stall_cnt counts every cycle ctrl_pc_o==Stalled
//   (not during rst).
// STRUCTURE
// - Encodings CTRL_STATE_Default/Stalled/Bubble, CTRL_Wire_Bus, FSM state
//   encodings live in defines.v.
// - One sub-module: load_use_detect (pure combinational comparator, 1b out).
// TESTING
// - Load x5 in EX, ID reads rs2=x5 -> one cycle pc/IF_ID=01, ID_EX=10; next cycle all 00.
// - Load to x0, ID reads x0 -> no stall, all 00.
// - ex_redirect_i pulse, FLUSH_CYCLES=1 -> cycle0 fire=1, IF_ID/ID_EX=10; cycle1 IF_ID=10; cycle2 all 00; flush_cnt=1.
// - mem_busy_i 3 cycles with redirect in cycle 1 -> 3 cycles pc..EX_MEM=01, MEM_WB=10, fire=0; cycle 4 fire=1.
// - rst mid-MEM_WAIT with pending redirect -> after rst state RUN, no fire, counters 0.
// - CNT_W=4, 17 stall cycles -> stall_cnt_o=1 (wrap).

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and types for the 5-stage pipeline controller.
package pipe_ctrl_pkg;

  typedef logic [1:0] ctrl_bus_t;

  localparam ctrl_bus_t CTRL_STATE_DEFAULT = 2'b00;
  localparam ctrl_bus_t CTRL_STATE_STALLED = 2'b01;
  localparam ctrl_bus_t CTRL_STATE_BUBBLE  = 2'b10;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
  localparam logic [ST_W-1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_FLUSH    = 2'd2;

  typedef struct packed {
    ctrl_bus_t pc;
    ctrl_bus_t if_id;
    ctrl_bus_t id_ex;
    ctrl_bus_t ex_mem;
    ctrl_bus_t mem_wb;
  } stage_ctrl_t;

  function automatic stage_ctrl_t stage_ctrl(
    input ctrl_bus_t pc,
    input ctrl_bus_t if_id,
    input ctrl_bus_t id_ex,
    input ctrl_bus_t ex_mem,
    input ctrl_bus_t mem_wb
  );
    stage_ctrl_t s;
    s.pc     = pc;
    s.if_id  = if_id;
    s.id_ex  = id_ex;
    s.ex_mem = ex_mem;
    s.mem_wb = mem_wb;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module pipe_ctrl_load_use_detect (
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_wreg,
  input  logic       ex_is_load,
  output logic       load_use_c
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr);

  // x0 is hardwired, so a load targeting it never creates a dependency
  assign load_use_c = ex_is_load && ex_wreg && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Per-stage stall/bubble control for the 5-stage core, with redirect flush
// sequencing, memory-wait stalling and performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_wreg_i,
  input  logic             ex_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             mem_busy_i,
  input  logic             if_busy_i,
  output logic [1:0]       ctrl_pc_o,
  output logic [1:0]       ctrl_if_id_o,
  output logic [1:0]       ctrl_id_ex_o,
  output logic [1:0]       ctrl_ex_mem_o,
  output logic [1:0]       ctrl_mem_wb_o,
  output logic             redirect_fire_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned FL_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FL_W-1:0] FLUSH_LOAD = FL_W'(FLUSH_CYCLES);

  localparam ctrl_bus_t D = CTRL_STATE_DEFAULT;
  localparam ctrl_bus_t S = CTRL_STATE_STALLED;
  localparam ctrl_bus_t B = CTRL_STATE_BUBBLE;

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_nxt;
  logic             pending_redirect;
  logic             pending_redirect_nxt;
  logic [FL_W-1:0]  flush_left;
  logic [FL_W-1:0]  flush_left_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  stage_ctrl_t      ctrl;
  logic             fire;
  logic             flush_inc;
  logic             load_use;
  logic             redirect_req;

  pipe_ctrl_load_use_detect u_load_use (
    .id_rs1_addr (id_rs1_addr_i),
    .id_rs2_addr (id_rs2_addr_i),
    .id_rs1_used (id_rs1_used_i),
    .id_rs2_used (id_rs2_used_i),
    .ex_rd_addr  (ex_rd_addr_i),
    .ex_wreg     (ex_wreg_i),
    .ex_is_load  (ex_is_load_i),
    .load_use_c  (load_use)
  );

  // A redirect parked during a memory wait is only replayed from MEM_WAIT
  assign redirect_req = ex_redirect_i || ((state == ST_MEM_WAIT) && pending_redirect);

  // Next-state and per-stage control, highest-priority condition first
  always_comb begin
    ctrl                 = stage_ctrl(D, D, D, D, D);
    fire                 = 1'b0;
    flush_inc            = 1'b0;
    state_nxt            = state;
    pending_redirect_nxt = pending_redirect;
    flush_left_nxt       = flush_left;

    if (rst) begin
      ctrl = stage_ctrl(S, B, B, B, B);
    end else if (mem_busy_i) begin
      ctrl      = stage_ctrl(S, S, S, S, B);
      state_nxt = ST_MEM_WAIT;
      if (ex_redirect_i) begin
        pending_redirect_nxt = 1'b1;
      end
    end else if (redirect_req) begin
      ctrl                 = stage_ctrl(D, B, B, D, D);
      fire                 = 1'b1;
      flush_inc            = 1'b1;
      pending_redirect_nxt = 1'b0;
      flush_left_nxt       = FLUSH_LOAD;
      state_nxt            = (FLUSH_CYCLES != 0) ? ST_FLUSH : ST_RUN;
    end else begin
      if (load_use) begin
        ctrl = stage_ctrl(S, S, B, D, D);
      end else if (flush_left != '0) begin
        ctrl           = stage_ctrl(D, B, D, D, D);
        flush_left_nxt = flush_left - FL_W'(1);
      end else if (if_busy_i) begin
        ctrl = stage_ctrl(S, B, D, D, D);
      end
      // Resumes an interrupted flush when leaving MEM_WAIT
      state_nxt = (flush_left_nxt != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_RUN;
      pending_redirect <= 1'b0;
      flush_left       <= '0;
    end else begin
      state            <= state_nxt;
      pending_redirect <= pending_redirect_nxt;
      flush_left       <= flush_left_nxt;
    end
  end

  // Counters wrap naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ctrl.pc == CTRL_STATE_STALLED) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign ctrl_pc_o       = ctrl.pc;
  assign ctrl_if_id_o    = ctrl.if_id;
  assign ctrl_id_ex_o    = ctrl.id_ex;
  assign ctrl_ex_mem_o   = ctrl.ex_mem;
  assign ctrl_mem_wb_o   = ctrl.mem_wb;
  assign redirect_fire_o = fire;
  assign stall_cnt_o     = stall_cnt;
  assign flush_cnt_o     = flush_cnt;

endmodule
